// File: rtl/inst_dispatcher.sv
// inst_dispatcher: host-fed instruction FIFO that issues one instruction
// at a time to Control and waits for Control's completion pulse.
// Ports:
//   clk, rstn          clock, synchronous active-low reset
//   host_inst/valid    enqueue side; host_ready high while not full
//   run                level enable for dispatch
//   ctrl_done          completion pulse for the outstanding instruction
//   inst/inst_valid    registered instruction and one-cycle issue strobe
//   busy               high while an instruction is issuing or outstanding
//   fifo_count         current FIFO occupancy
//   program_done       sticky, END marker consumed
//   timeout_err        sticky, watchdog expired
module inst_dispatcher #(
   parameter int         INST_WIDTH     = 27,
   parameter int         FIFO_DEPTH     = 16,
   parameter int         PTR_WIDTH      = 4,
   parameter int         TIMEOUT_CYCLES = 4096,
   parameter logic [3:0] END_OPCODE     = 4'hF
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [INST_WIDTH-1:0] host_inst,
   input  logic                  host_valid,
   output logic                  host_ready,
   input  logic                  run,
   input  logic                  ctrl_done,
   output logic [INST_WIDTH-1:0] inst,
   output logic                  inst_valid,
   output logic                  busy,
   output logic [PTR_WIDTH:0]    fifo_count,
   output logic                  program_done,
   output logic                  timeout_err
);

   localparam int LP_WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [PTR_WIDTH:0] LP_FULL =
      (PTR_WIDTH+1)'(FIFO_DEPTH);
   localparam logic [LP_WW-1:0] LP_WLAST =
      LP_WW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_HALT,
      S_ERROR
   } state_t;

   state_t                r_state;
   logic [INST_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]  r_wptr;
   logic [PTR_WIDTH-1:0]  r_rptr;
   logic [PTR_WIDTH:0]    r_count;
   logic [LP_WW-1:0]      r_wdog;
   logic [INST_WIDTH-1:0] r_inst;
   logic                  r_inst_valid;
   logic                  r_prog_done;
   logic                  r_tmo;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_avail;
   logic                  w_head_end;
   logic                  w_go;
   logic [INST_WIDTH-1:0] w_head;

   assign host_ready = (r_count != LP_FULL);
   assign w_push     = host_valid && host_ready;
   assign w_head     = r_mem[r_rptr];
   assign w_head_end = (w_head[INST_WIDTH-1 -: 4] == END_OPCODE);
   // Occupancy is taken from the registered count, so data pushed
   // into an empty FIFO this cycle is never seen as available.
   assign w_avail    = run && (r_count != '0);
   assign w_go       = w_avail && !w_head_end;
   // Head leaves the FIFO when issued, or when an END marker is
   // consumed from IDLE.
   assign w_pop      = (r_count != '0) &&
                       ((r_state == S_ISSUE) ||
                        ((r_state == S_IDLE) && w_avail && w_head_end));

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= host_inst;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state      <= S_IDLE;
         r_inst       <= '0;
         r_inst_valid <= 1'b0;
         r_prog_done  <= 1'b0;
         r_tmo        <= 1'b0;
         r_wdog       <= '0;
      end else begin
         r_inst_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_go) begin
                  r_state <= S_ISSUE;
               end else if (w_avail) begin
                  r_prog_done <= 1'b1;
                  r_state     <= S_HALT;
               end
            end
            S_ISSUE: begin
               r_inst       <= w_head;
               r_inst_valid <= 1'b1;
               r_wdog       <= '0;
               r_state      <= S_WAIT;
            end
            S_WAIT: begin
               // A done coincident with the strobe is too early to be
               // real; a done on the last watchdog count still wins.
               if (ctrl_done && !r_inst_valid) begin
                  r_state <= w_go ? S_ISSUE : S_IDLE;
               end else if (r_wdog == LP_WLAST) begin
                  r_tmo   <= 1'b1;
                  r_state <= S_ERROR;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            S_HALT: begin
               if (w_push && r_prog_done) begin
                  r_prog_done <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            S_ERROR: begin
               r_state <= S_ERROR;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign inst         = r_inst;
   assign inst_valid   = r_inst_valid;
   assign busy         = (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign fifo_count   = r_count;
   assign program_done = r_prog_done;
   assign timeout_err  = r_tmo;

endmodule
